// File: rtl/ucie_ctl_sb_rx_deser_if.sv
// ---------------------------------------------------------------------------
// ucie_ctl_sb_rx_deser_if
//
// Purpose:
//   Bundles the lane-side beat stream and the word-side valid/ready holding
//   register of the sideband RX deserializer into one interface.
//
// Signals:
//   i_valid       beat strobe from the lane sampler (no backpressure)
//   i_data        LANE_W-bit beat payload
//   i_mode        word size select: 0 = 32-bit word, 1 = 64-bit word
//   i_word_ready  packet decoder accepts o_word
//   o_word        assembled MAX_W-bit word
//   o_word_valid  o_word holds an unconsumed word
//
// Modports:
//   master  the environment: drives beats and ready, observes the word
//   slave   the deserializer: consumes beats and ready, drives the word
// ---------------------------------------------------------------------------
interface ucie_ctl_sb_rx_deser_if #(
  parameter int LANE_W = 16,
  parameter int MAX_W  = 64
);
  logic              i_valid;
  logic [LANE_W-1:0] i_data;
  logic              i_mode;
  logic              i_word_ready;
  logic [MAX_W-1:0]  o_word;
  logic              o_word_valid;

  modport master (
    output i_valid,
    output i_data,
    output i_mode,
    output i_word_ready,
    input  o_word,
    input  o_word_valid
  );

  modport slave (
    input  i_valid,
    input  i_data,
    input  i_mode,
    input  i_word_ready,
    output o_word,
    output o_word_valid
  );
endinterface

// File: rtl/ucie_ctl_sb_rx_deser.sv
// ---------------------------------------------------------------------------
// ucie_ctl_sb_rx_deser
//
// Purpose:
//   Sideband RX deserializer and beat counter. LANE_W-bit beats are packed
//   little-endian (beat 0 in the LSBs) into a 32-bit or 64-bit word, the size
//   being chosen by i_mode on the first beat of each word. A completed word
//   is presented through a single valid/ready holding register one cycle
//   after its last beat. A word that completes while the holding register is
//   full and not being drained is dropped and a sticky overflow flag is set.
//   i_clear flushes the partial word and the overflow flag without touching
//   the holding register.
//
// Ports:
//   i_clk         clock, rising edge
//   i_reset       asynchronous, active-low reset
//   i_clear       synchronous flush of partial word and overflow flag
//   sb            beat / word interface (slave modport)
//   o_beat_cnt    index of the next beat within the current word
//   o_first_beat  1 when o_beat_cnt == 0 (combinational)
//   o_overflow    sticky: a completed word was dropped
//
// Parameters:
//   LANE_W  beat width; must divide 32 (1, 2, 4, 8, 16, 32)
//   MAX_W   widest word; fixed at 64
//   CNT_W   beat counter width, derived from MAX_W/LANE_W
// ---------------------------------------------------------------------------
module ucie_ctl_sb_rx_deser #(
  parameter  int LANE_W = 16,
  parameter  int MAX_W  = 64,
  localparam int CNT_W  = ($clog2(MAX_W / LANE_W) < 1) ? 1
                                                       : $clog2(MAX_W / LANE_W)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_clear,
  ucie_ctl_sb_rx_deser_if.slave  sb,
  output logic [CNT_W-1:0]       o_beat_cnt,
  output logic                   o_first_beat,
  output logic                   o_overflow
);

  localparam int BEATS_MAX = MAX_W / LANE_W;
  localparam int BEATS_32  = 32 / LANE_W;

  // Index of the final beat for each word size.
  localparam logic [CNT_W-1:0] LAST_32 = CNT_W'(BEATS_32 - 1);
  localparam logic [CNT_W-1:0] LAST_64 = CNT_W'(BEATS_MAX - 1);

  // Keeps only the low 32 bits of a completion word in 32-bit mode.
  localparam logic [MAX_W-1:0] LO32_MASK = {{(MAX_W-32){1'b0}}, {32{1'b1}}};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             mode_q,       mode_d;
  logic [MAX_W-1:0] acc_q,        acc_d;
  logic [MAX_W-1:0] word_q,       word_d;
  logic             word_vld_q,   word_vld_d;
  logic             ovf_q,        ovf_d;

  // -------------------------------------------------------------------------
  // Beat acceptance and word completion
  // -------------------------------------------------------------------------
  logic             accept;
  logic             mode_eff;
  logic [CNT_W-1:0] last_idx;
  logic             last_beat;
  logic [MAX_W-1:0] merged;
  logic [MAX_W-1:0] completion;
  logic             load_word;
  logic             drop_word;
  logic             drain_word;

  // Clear wins over a coincident beat.
  assign accept = sb.i_valid & ~i_clear;

  // On beat 0 the mode comes straight from the pin so the very first beat
  // already knows its word size; afterwards the latched copy is used and
  // mid-word changes of i_mode have no effect.
  assign mode_eff  = (cnt_q == '0) ? sb.i_mode : mode_q;
  assign last_idx  = mode_eff ? LAST_64 : LAST_32;
  assign last_beat = accept & (cnt_q == last_idx);

  // Current beat merged into the accumulator at slot cnt_q.
  always_comb begin
    merged = acc_q;
    for (int b = 0; b < BEATS_MAX; b++) begin
      if (cnt_q == CNT_W'(b)) begin
        merged[b*LANE_W +: LANE_W] = sb.i_data;
      end
    end
  end

  assign completion = mode_eff ? merged : (merged & LO32_MASK);

  // Holding register decisions for this cycle.
  assign load_word  = last_beat & (~word_vld_q | sb.i_word_ready);
  assign drop_word  = last_beat & word_vld_q & ~sb.i_word_ready;
  assign drain_word = ~last_beat & word_vld_q & sb.i_word_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    word_d     = word_q;
    word_vld_d = word_vld_q;
    ovf_d      = ovf_q;

    if (i_clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      if (cnt_q == '0) begin
        mode_d = sb.i_mode;
      end
      if (last_beat) begin
        cnt_d = '0;
        // Start the next word from a clean accumulator so no stale upper
        // bits can leak into a later word.
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = merged;
      end
    end

    // The ready handshake is independent of i_clear.
    if (load_word) begin
      word_d     = completion;
      word_vld_d = 1'b1;
    end else if (drain_word) begin
      word_vld_d = 1'b0;
    end

    if (i_clear) begin
      ovf_d = 1'b0;
    end else if (drop_word) begin
      ovf_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      acc_q      <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign sb.o_word       = word_q;
  assign sb.o_word_valid = word_vld_q;
  assign o_beat_cnt      = cnt_q;
  assign o_first_beat    = (cnt_q == '0);
  assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_ucie_ctl_sb_rx_deser.sv
// ---------------------------------------------------------------------------
// tb_ucie_ctl_sb_rx_deser
//
// Directed bench for the sideband RX deserializer at LANE_W=16, MAX_W=64.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_ucie_ctl_sb_rx_deser;

  localparam int LANE_W = 16;
  localparam int MAX_W  = 64;
  localparam int CNT_W  = 2;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_clear;
  logic [CNT_W-1:0] o_beat_cnt;
  logic             o_first_beat;
  logic             o_overflow;

  int n_chk  = 0;
  int n_fail = 0;

  ucie_ctl_sb_rx_deser_if #(.LANE_W(LANE_W), .MAX_W(MAX_W)) sb ();

  ucie_ctl_sb_rx_deser #(.LANE_W(LANE_W), .MAX_W(MAX_W)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (i_clear),
    .sb           (sb.slave),
    .o_beat_cnt   (o_beat_cnt),
    .o_first_beat (o_first_beat),
    .o_overflow   (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present one beat for one clock.
  task automatic beat(input logic [LANE_W-1:0] d, input logic m);
    sb.i_valid = 1'b1;
    sb.i_data  = d;
    sb.i_mode  = m;
    tick();
    sb.i_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] w,
                         input logic wv, input logic [CNT_W-1:0] c,
                         input logic ovf);
    chk({tag, ".word"}, sb.o_word, w);
    chk({tag, ".wv"},   {63'd0, sb.o_word_valid}, {63'd0, wv});
    chk({tag, ".cnt"},  {62'd0, o_beat_cnt}, {62'd0, c});
    chk({tag, ".first"}, {63'd0, o_first_beat}, {63'd0, (c == 2'd0)});
    chk({tag, ".ovf"},  {63'd0, o_overflow}, {63'd0, ovf});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset         = 1'b0;
    i_clear         = 1'b0;
    sb.i_valid      = 1'b0;
    sb.i_data       = '0;
    sb.i_mode       = 1'b0;
    sb.i_word_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk_out("rst", 64'h0, 1'b0, 2'd0, 1'b0);
    i_reset = 1'b1;
    tick();

    // 32-bit word, ready high: count 0,1,0; valid exactly one cycle
    chk("m0.cnt0", {62'd0, o_beat_cnt}, 64'd0);
    beat(16'h1111, 1'b0);
    chk_out("m0.b0", 64'h0, 1'b0, 2'd1, 1'b0);
    beat(16'h2222, 1'b0);
    chk_out("m0.b1", 64'h0000_0000_2222_1111, 1'b1, 2'd0, 1'b0);
    tick();
    chk_out("m0.drain", 64'h0000_0000_2222_1111, 1'b0, 2'd0, 1'b0);

    // 64-bit word
    beat(16'hAAAA, 1'b1);
    chk_out("m1.b0", 64'h0000_0000_2222_1111, 1'b0, 2'd1, 1'b0);
    beat(16'hBBBB, 1'b1);
    chk_out("m1.b1", 64'h0000_0000_2222_1111, 1'b0, 2'd2, 1'b0);
    beat(16'hCCCC, 1'b1);
    chk_out("m1.b2", 64'h0000_0000_2222_1111, 1'b0, 2'd3, 1'b0);
    beat(16'hDDDD, 1'b1);
    chk_out("m1.b3", 64'hDDDD_CCCC_BBBB_AAAA, 1'b1, 2'd0, 1'b0);
    tick();
    chk("m1.drain", {63'd0, sb.o_word_valid}, 64'd0);

    // Backpressure: second word dropped, overflow sticky until clear
    sb.i_word_ready = 1'b0;
    beat(16'h0001, 1'b0);
    beat(16'h0002, 1'b0);
    chk_out("bp.w1", 64'h0000_0000_0002_0001, 1'b1, 2'd0, 1'b0);
    beat(16'h0003, 1'b0);
    beat(16'h0004, 1'b0);
    chk_out("bp.w2", 64'h0000_0000_0002_0001, 1'b1, 2'd0, 1'b1);
    sb.i_word_ready = 1'b1;
    tick();
    chk_out("bp.rdy", 64'h0000_0000_0002_0001, 1'b0, 2'd0, 1'b1);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk_out("bp.clr", 64'h0000_0000_0002_0001, 1'b0, 2'd0, 1'b0);

    // Ready on the same cycle a new word completes: reload, no overflow
    sb.i_word_ready = 1'b0;
    beat(16'h5555, 1'b0);
    beat(16'h6666, 1'b0);
    chk_out("rl.w1", 64'h0000_0000_6666_5555, 1'b1, 2'd0, 1'b0);
    beat(16'h7777, 1'b0);
    sb.i_word_ready = 1'b1;
    beat(16'h8888, 1'b0);
    chk_out("rl.w2", 64'h0000_0000_8888_7777, 1'b1, 2'd0, 1'b0);
    tick();
    chk("rl.drain", {63'd0, sb.o_word_valid}, 64'd0);

    // Mode change mid-word is ignored
    beat(16'h0101, 1'b1);
    beat(16'h0202, 1'b0);
    chk_out("mc.b1", 64'h0000_0000_8888_7777, 1'b0, 2'd2, 1'b0);
    beat(16'h0303, 1'b0);
    beat(16'h0404, 1'b0);
    chk_out("mc.b3", 64'h0404_0303_0202_0101, 1'b1, 2'd0, 1'b0);
    tick();

    // Clear after two beats, coincident beat discarded, then fresh word
    beat(16'h1234, 1'b1);
    beat(16'h5678, 1'b1);
    chk("cl.pre", {62'd0, o_beat_cnt}, 64'd2);
    i_clear = 1'b1;
    beat(16'hFFFF, 1'b1);
    i_clear = 1'b0;
    chk("cl.cnt", {62'd0, o_beat_cnt}, 64'd0);
    beat(16'h0A0A, 1'b1);
    beat(16'h0B0B, 1'b1);
    beat(16'h0C0C, 1'b1);
    chk("cl.wv3", {63'd0, sb.o_word_valid}, 64'd0);
    beat(16'h0D0D, 1'b1);
    chk_out("cl.w", 64'h0D0D_0C0C_0B0B_0A0A, 1'b1, 2'd0, 1'b0);
    tick();

    // Asynchronous reset mid-word with a held word
    sb.i_word_ready = 1'b0;
    beat(16'h0011, 1'b0);
    beat(16'h0022, 1'b0);
    beat(16'h9999, 1'b1);
    chk_out("ar.pre", 64'h0000_0000_0022_0011, 1'b1, 2'd1, 1'b0);
    #2;
    i_reset = 1'b0;
    #1;
    chk_out("ar.in", 64'h0, 1'b0, 2'd0, 1'b0);
    tick();
    i_reset = 1'b1;
    sb.i_word_ready = 1'b1;
    beat(16'h1000, 1'b1);
    beat(16'h2000, 1'b1);
    beat(16'h3000, 1'b1);
    beat(16'h4000, 1'b1);
    chk_out("ar.post", 64'h4000_3000_2000_1000, 1'b1, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ucie_ctl_sb_rx_deser.md
Name: ucie_ctl_sb_rx_deser

Overview:
Parametrised sideband RX deserializer and beat counter. It accumulates LANE_W-bit beats into a 32-bit or 64-bit word, selected per word, and presents each completed word through a valid/ready holding register. It tracks beat position, flags words lost to backpressure, and supports a synchronous flush. It sits between the sideband lane sampler and the SB RX packet decoder.

Parameters:
LANE_W, 16, beat width in bits; must divide 32 (legal values 1, 2, 4, 8, 16, 32).
MAX_W, 64, widest word in bits; fixed at 64; must be a multiple of LANE_W.
CNT_W, max(1, $clog2(MAX_W/LANE_W)), beat counter width; derived, not overridden.

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_reset  input  1  asynchronous, active-low reset.
i_clear  input  1  synchronous flush of the partial word and the overflow flag.
i_valid  input  1  beat strobe; no backpressure toward the lane side.
i_data  input  LANE_W  beat payload.
i_mode  input  1  0 = 32-bit word, 1 = 64-bit word.
i_word_ready  input  1  consumer accepts o_word.
o_word  output  MAX_W  assembled word.
o_word_valid  output  1  o_word holds an unconsumed word.
o_beat_cnt  output  CNT_W  index of the next beat within the current word.
o_first_beat  output  1  combinational; 1 when o_beat_cnt == 0.
o_overflow  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset: i_reset low clears all of the following to 0 immediately, regardless of clock: count, latched mode, partial accumulator, o_word, o_word_valid, o_overflow. o_first_beat = 1 in reset.
- Beats per word: BPW = 32/LANE_W in mode 0, MAX_W/LANE_W in mode 1.
- Mode latch: i_mode is sampled only on an accepted beat with count == 0. It is held for the rest of the word. Changes to i_mode mid-word are ignored.
- Beat accept: when i_valid=1 and i_clear=0, the beat is stored at bits [k*LANE_W +: LANE_W] of the accumulator, where k = current count (little-endian, beat 0 in the LSBs).
- Count update on an accepted beat:
  - If k == BPW-1, count wraps to 0.
  - Otherwise count increments by 1.
  - No change without i_valid.
- Word completion: on the cycle the last beat is accepted, the full word (current beat merged in) is the completion word. In mode 0, bits [63:32] of the completion word are 0.
- Output register:
  - Completion with o_word_valid=0, or with o_word_valid=1 and i_word_ready=1: o_word <= completion word, o_word_valid <= 1 next cycle. Latency is 1 cycle from last-beat acceptance to o_word_valid.
  - Completion with o_word_valid=1 and i_word_ready=0: the new word is dropped, o_word keeps the old value, o_overflow <= 1.
  - No completion, o_word_valid=1, i_word_ready=1: o_word_valid <= 0. o_word keeps its last value.
- o_word is stable while o_word_valid=1 and i_word_ready=0.
- i_clear:
  - Count <= 0, accumulator <= 0, o_overflow <= 0.
  - Any i_valid in the same cycle is discarded (clear wins).
  - o_word and o_word_valid are unaffected; the ready handshake still completes in that cycle.
- o_overflow stays set until i_clear or reset.
- LANE_W=32 in mode 0 gives BPW=1: every beat completes a word, and the count stays 0.

Test Plan:
- LANE_W=16, mode 0, beats 0x1111 then 0x2222, ready=1 -> o_word=0x0000_0000_2222_1111; o_word_valid high exactly 1 cycle after the 2nd beat; o_beat_cnt sequence 0,1,0.
- Mode 1, beats 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD -> o_word=0xDDDD_CCCC_BBBB_AAAA; o_first_beat high only before beat 0 and after beat 3.
- Hold ready=0 and send two full mode-0 words -> first word held unchanged, o_overflow=1. Then ready=1 -> o_word_valid drops. Then i_clear -> o_overflow=0.
- Ready=1 on the same cycle a new word completes while o_word_valid=1 -> new word loaded, o_word_valid stays 1, o_overflow stays 0.
- Mode 1, beat 0 sent, then i_mode toggled to 0, then 3 more beats -> 64-bit word produced.
- i_clear after 2 beats, then 4 fresh beats -> only the fresh word is output.
- Reset asserted mid-word with o_word_valid=1 -> all outputs 0 immediately, o_first_beat=1; after release, the next 4 beats assemble a clean word.
